// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode byte stream -> one event per key action (make/break, E0/F0/E1 prefixes).
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses typematic repeats of the held key.
module ps2_scancode_decoder #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_release,
    output logic [7:0]       key_ascii,
    output logic             key_down,
    output logic [CNT_W-1:0] press_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXT     = 3'd1;
    localparam logic [2:0] S_BRK     = 3'd2;
    localparam logic [2:0] S_EXT_BRK = 3'd3;
    localparam logic [2:0] S_PAUSE   = 3'd4;

    localparam int         TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [2:0]    state, state_nxt;
    logic [2:0]    skip, skip_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_exp;
    logic          ev, ev_ext, ev_rel;
    logic          held_vld, held_ext;
    logic [7:0]    held_code;
    logic          is_make, held_match, emit;

    function automatic logic [7:0] to_ascii(input logic [7:0] c);
        case (c)
            8'h1C: to_ascii = 8'h61; 8'h32: to_ascii = 8'h62; 8'h21: to_ascii = 8'h63;
            8'h23: to_ascii = 8'h64; 8'h24: to_ascii = 8'h65; 8'h2B: to_ascii = 8'h66;
            8'h34: to_ascii = 8'h67; 8'h33: to_ascii = 8'h68; 8'h43: to_ascii = 8'h69;
            8'h3B: to_ascii = 8'h6A; 8'h42: to_ascii = 8'h6B; 8'h4B: to_ascii = 8'h6C;
            8'h3A: to_ascii = 8'h6D; 8'h31: to_ascii = 8'h6E; 8'h44: to_ascii = 8'h6F;
            8'h4D: to_ascii = 8'h70; 8'h15: to_ascii = 8'h71; 8'h2D: to_ascii = 8'h72;
            8'h1B: to_ascii = 8'h73; 8'h2C: to_ascii = 8'h74; 8'h3C: to_ascii = 8'h75;
            8'h2A: to_ascii = 8'h76; 8'h1D: to_ascii = 8'h77; 8'h22: to_ascii = 8'h78;
            8'h35: to_ascii = 8'h79; 8'h1A: to_ascii = 8'h7A;
            8'h45: to_ascii = 8'h30; 8'h16: to_ascii = 8'h31; 8'h1E: to_ascii = 8'h32;
            8'h26: to_ascii = 8'h33; 8'h25: to_ascii = 8'h34; 8'h2E: to_ascii = 8'h35;
            8'h36: to_ascii = 8'h36; 8'h3D: to_ascii = 8'h37; 8'h3E: to_ascii = 8'h38;
            8'h46: to_ascii = 8'h39;
            default: to_ascii = 8'h00;
        endcase
    endfunction

    // Expiry only when no byte arrives this cycle: a coincident byte is parsed in the current state.
    assign tmo_exp = (TIMEOUT_CYC > 0) && (state != S_IDLE) && !in_valid && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip;
        ev        = 1'b0;
        ev_ext    = 1'b0;
        ev_rel    = 1'b0;
        if (in_valid) begin
            case (state)
                S_IDLE: begin
                    case (in_data)
                        8'hE0: state_nxt = S_EXT;
                        8'hF0: state_nxt = S_BRK;
                        8'hE1: begin
                            state_nxt = S_PAUSE;
                            skip_nxt  = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                        default: ev = 1'b1;
                    endcase
                end
                S_EXT: begin
                    case (in_data)
                        8'hF0:        state_nxt = S_EXT_BRK;
                        8'hE0, 8'hE1: state_nxt = S_EXT;
                        default: begin
                            ev        = 1'b1;
                            ev_ext    = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    endcase
                end
                S_BRK: begin
                    ev        = 1'b1;
                    ev_rel    = 1'b1;
                    state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    ev        = 1'b1;
                    ev_ext    = 1'b1;
                    ev_rel    = 1'b1;
                    state_nxt = S_IDLE;
                end
                S_PAUSE: begin
                    skip_nxt = skip - 3'd1;
                    if (skip == 3'd1) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (tmo_exp) begin
            state_nxt = S_IDLE;
        end
    end

    assign is_make    = ev && !ev_rel;
    assign held_match = held_vld && (held_code == in_data) && (held_ext == ev_ext);
`ifdef PS2_TYPEMATIC_FILTER_EN
    assign emit = ev && !(is_make && held_match);
`else
    assign emit = ev;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            skip        <= '0;
            tmo_cnt     <= '0;
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_ascii   <= '0;
            held_vld    <= 1'b0;
            held_ext    <= 1'b0;
            held_code   <= '0;
            press_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            skip      <= skip_nxt;
            key_valid <= emit;
            if (in_valid || state == S_IDLE || tmo_exp) tmo_cnt <= '0;
            else                                        tmo_cnt <= tmo_cnt + TW'(1);
            if (emit) begin
                key_code    <= in_data;
                key_ext     <= ev_ext;
                key_release <= ev_rel;
                key_ascii   <= to_ascii(in_data);
            end
            if (is_make) begin
                held_vld  <= 1'b1;
                held_code <= in_data;
                held_ext  <= ev_ext;
            end else if (ev && held_match) begin
                held_vld <= 1'b0;
            end
            if (emit && is_make) press_cnt <= press_cnt + CNT_W'(1);
        end
    end

    assign key_down = held_vld;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Table-driven bench for ps2_scancode_decoder: expected events queued at drive time, checked on key_valid.
module tb_ps2_scancode_decoder;

    localparam int CNT_W = 4;
    localparam int TMO   = 16;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam int C9 = 4;
`else
    localparam int C9 = 6;
`endif

    logic             clk, rst, in_valid;
    logic [7:0]       in_data;
    logic             key_valid, key_ext, key_release, key_down;
    logic [7:0]       key_code, key_ascii;
    logic [CNT_W-1:0] press_cnt;

    ps2_scancode_decoder #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_release(key_release), .key_ascii(key_ascii), .key_down(key_down),
        .press_cnt(press_cnt)
    );

    typedef struct {
        logic [7:0] b;
        bit         ev;
        logic [7:0] code;
        bit         ext;
        bit         rel;
        logic [7:0] ascii;
        bit         down;
        int         cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    vec_t e;
    int   checks = 0;
    int   errors = 0;
    int   cnt_base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] b, input bit ev, input logic [7:0] code, input bit ext,
                       input bit rel, input logic [7:0] ascii, input bit down, input int cnt);
        vec_t v;
        v.b = b; v.ev = ev; v.code = code; v.ext = ext; v.rel = rel;
        v.ascii = ascii; v.down = down; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic nop(input logic [7:0] b);
        add(b, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic step(input vec_t v);
        if (v.ev) exp_q.push_back(v);
        send(v.b);
    endtask

    task automatic check_zero();
        chk("rst_key_valid", 32'(key_valid), 0);
        chk("rst_key_code", 32'(key_code), 0);
        chk("rst_key_ext", 32'(key_ext), 0);
        chk("rst_key_release", 32'(key_release), 0);
        chk("rst_key_ascii", 32'(key_ascii), 0);
        chk("rst_key_down", 32'(key_down), 0);
        chk("rst_press_cnt", 32'(press_cnt), 0);
    endtask

    // Scoreboard: every key_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && key_valid) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_event actual=%0h expected=none", key_code);
            end else begin
                e = exp_q.pop_front();
                chk("key_code", 32'(key_code), 32'(e.code));
                chk("key_ext", 32'(key_ext), 32'(e.ext));
                chk("key_release", 32'(key_release), 32'(e.rel));
                chk("key_ascii", 32'(key_ascii), 32'(e.ascii));
                chk("key_down", 32'(key_down), 32'(e.down));
                chk("press_cnt", 32'(press_cnt), 32'(e.cnt % (1 << CNT_W)));
            end
        end
    end

    initial begin
        vec_t v;
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        check_zero();
        rst = 1'b1;

        // Spec examples and prefix handling
        add(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, 1);
        nop(8'hF0);
        add(8'h1C, 1, 8'h1C, 0, 1, 8'h61, 0, 1);
        nop(8'hE0);
        add(8'h75, 1, 8'h75, 1, 0, 8'h00, 1, 2);
        nop(8'hE0); nop(8'hF0);
        add(8'h75, 1, 8'h75, 1, 1, 8'h00, 0, 2);
        nop(8'hE1); nop(8'h14); nop(8'h77); nop(8'hE1);
        nop(8'hF0); nop(8'h14); nop(8'hF0); nop(8'h77);
        add(8'h45, 1, 8'h45, 0, 0, 8'h30, 1, 3);
        nop(8'hF0);
        add(8'h45, 1, 8'h45, 0, 1, 8'h30, 0, 3);
        nop(8'hAA); nop(8'hFA); nop(8'hEE); nop(8'hFE); nop(8'h00); nop(8'hFF);
        // Typematic repeats
        add(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, 4);
`ifdef PS2_TYPEMATIC_FILTER_EN
        nop(8'h1C); nop(8'h1C);
`else
        add(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, 5);
        add(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, 6);
`endif
        nop(8'hF0);
        add(8'h1C, 1, 8'h1C, 0, 1, 8'h61, 0, C9);
        // Break of a non-held key leaves key_down alone
        add(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, C9 + 1);
        nop(8'hF0);
        add(8'h32, 1, 8'h32, 0, 1, 8'h62, 1, C9 + 1);
        nop(8'hF0);
        add(8'h1C, 1, 8'h1C, 0, 1, 8'h61, 0, C9 + 1);
        // Held key identity includes the ext flag
        add(8'h75, 1, 8'h75, 0, 0, 8'h00, 1, C9 + 2);
        nop(8'hE0); nop(8'hF0);
        add(8'h75, 1, 8'h75, 1, 1, 8'h00, 1, C9 + 2);
        nop(8'hF0);
        add(8'h75, 1, 8'h75, 0, 1, 8'h00, 0, C9 + 2);
        add(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, C9 + 3);
        nop(8'hE0);
        add(8'h1C, 1, 8'h1C, 1, 0, 8'h61, 1, C9 + 4);
        nop(8'hF0);
        add(8'h1C, 1, 8'h1C, 0, 1, 8'h61, 1, C9 + 4);
        nop(8'hE0); nop(8'hF0);
        add(8'h1C, 1, 8'h1C, 1, 1, 8'h61, 0, C9 + 4);
        // Repeated E0 stays extended; digit mapping
        nop(8'hE0); nop(8'hE0);
        add(8'h1C, 1, 8'h1C, 1, 0, 8'h61, 1, C9 + 5);
        nop(8'hE0); nop(8'hF0);
        add(8'h1C, 1, 8'h1C, 1, 1, 8'h61, 0, C9 + 5);
        add(8'h16, 1, 8'h16, 0, 0, 8'h31, 1, C9 + 6);
        nop(8'hF0);
        add(8'h16, 1, 8'h16, 0, 1, 8'h31, 0, C9 + 6);
        // press_cnt wraps through zero
        cnt_base = C9 + 6;
        for (int i = 1; i <= 10; i++) begin
            add(8'h2B, 1, 8'h2B, 0, 0, 8'h66, 1, cnt_base + i);
            nop(8'hF0);
            add(8'h2B, 1, 8'h2B, 0, 1, 8'h66, 0, cnt_base + i);
        end
        cnt_base = cnt_base + 10;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            step(v);
        end

        // Timeout: short idle keeps the prefix, long idle abandons it
        send(8'hE0);
        repeat (TMO / 2) @(negedge clk);
        v.b = 8'h75; v.ev = 1; v.code = 8'h75; v.ext = 1; v.rel = 0; v.ascii = 8'h00;
        v.down = 1; v.cnt = cnt_base + 1;
        step(v);
        send(8'hE0); send(8'hF0);
        v.rel = 1; v.down = 0;
        step(v);
        send(8'hE0);
        repeat (TMO + 4) @(negedge clk);
        v.b = 8'h1C; v.code = 8'h1C; v.ext = 0; v.rel = 0; v.ascii = 8'h61;
        v.down = 1; v.cnt = cnt_base + 2;
        step(v);

        // Reset in the middle of a break prefix
        send(8'hF0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        v.b = 8'h1C; v.code = 8'h1C; v.ext = 0; v.rel = 0; v.ascii = 8'h61;
        v.down = 1; v.cnt = 1;
        step(v);

        repeat (4) @(negedge clk);
        chk("events_pending", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
